// File: rtl/warn_lamp_driver.sv
// rtl/warn_lamp_driver.sv - brake-oil warning lamp/buzzer alarm stage with glitch filter
//
// Consumes the brake-oil warning level and rejects glitches shorter than
// CONFIRM_CYCLES. While the alarm is unacknowledged it blinks the lamp and
// sounds the buzzer for a limited time. Once acknowledged it holds the lamp
// steady until the warning has stayed clear for CLEAR_CYCLES. It also counts
// confirmed alarm events, saturating at 255.
//
// Optional build macro:
//   WARN_LATCH_EN  when defined, an unacknowledged alarm ignores warn=0 and is
//                  left only through ack (the alarm stays latched).
//
// Ports:
//   clock           in   1  system clock, rising edge
//   reset           in   1  asynchronous active-low reset
//   warn_break_oil  in   1  warning level from the brake-oil detector
//   ack             in   1  driver acknowledge (level)
//   lamp            out  1  warning lamp drive (registered)
//   buzzer          out  1  buzzer drive (registered)
//   alarm_active    out  1  high in ALARM, ACKED and CLEARING (registered)
//   warn_count      out  8  confirmed-alarm counter, saturating

module warn_lamp_driver #(
    parameter int CONFIRM_CYCLES = 8,
    parameter int BLINK_HALF     = 16,
    parameter int BUZZ_CYCLES    = 64,
    parameter int CLEAR_CYCLES   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       warn_break_oil,
    input  logic       ack,
    output logic       lamp,
    output logic       buzzer,
    output logic       alarm_active,
    output logic [7:0] warn_count
);

    // The confirm and clear phases never overlap, so they share one counter
    // sized for the larger of the two limits.
    localparam int CONF_W  = $clog2(CONFIRM_CYCLES);
    localparam int CLR_W   = $clog2(CLEAR_CYCLES);
    localparam int CNT_RAW = (CONF_W > CLR_W) ? CONF_W : CLR_W;
    localparam int CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;
    localparam int BLK_RAW = $clog2(BLINK_HALF);
    localparam int BLK_W   = (BLK_RAW > 0) ? BLK_RAW : 1;
    localparam int BUZ_RAW = $clog2(BUZZ_CYCLES);
    localparam int BUZ_W   = (BUZ_RAW > 0) ? BUZ_RAW : 1;

    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [BLK_W-1:0] BLINK_LAST   = BLK_W'(BLINK_HALF - 1);
    localparam logic [BUZ_W-1:0] BUZZ_LAST    = BUZ_W'(BUZZ_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONFIRM  = 3'd1,
        ST_ALARM    = 3'd2,
        ST_ACKED    = 3'd3,
        ST_CLEARING = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] blink_q, blink_d;
    logic [BUZ_W-1:0] buzz_q, buzz_d;
    logic             acked_q, acked_d;
    logic             lamp_q, lamp_d;
    logic             buzzer_q, buzzer_d;
    logic             active_q, active_d;
    logic [7:0]       count_q, count_d;

    logic             enter_alarm;
    logic             alarm_lamp;
    logic             alarm_buzz;
    logic             clear_on_low;

`ifdef WARN_LATCH_EN
    assign clear_on_low = 1'b0;
`else
    assign clear_on_low = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            blink_q  <= '0;
            buzz_q   <= '0;
            acked_q  <= 1'b0;
            lamp_q   <= 1'b0;
            buzzer_q <= 1'b0;
            active_q <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
            buzz_q   <= buzz_d;
            acked_q  <= acked_d;
            lamp_q   <= lamp_d;
            buzzer_q <= buzzer_d;
            active_q <= active_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blink_d     = blink_q;
        buzz_d      = buzz_q;
        acked_d     = acked_q;
        count_d     = count_q;
        enter_alarm = 1'b0;
        alarm_lamp  = lamp_q;
        alarm_buzz  = buzzer_q;

        unique case (state_q)
            ST_IDLE: begin
                if (warn_break_oil) begin
                    state_d = ST_CONFIRM;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_CONFIRM: begin
                if (!warn_break_oil) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CONFIRM_LAST) begin
                    enter_alarm = 1'b1;
                    acked_d     = 1'b0;
                    count_d     = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_ALARM: begin
                if (ack) begin
                    state_d = ST_ACKED;
                    acked_d = 1'b1;
                end else if (!warn_break_oil && clear_on_low) begin
                    state_d = ST_CLEARING;
                    cnt_d   = CNT_ONE;
                end else begin
                    if (blink_q == BLINK_LAST) begin
                        blink_d    = '0;
                        alarm_lamp = ~lamp_q;
                    end else begin
                        blink_d = blink_q + BLK_W'(1);
                    end
                    // The buzz timer freezes once the buzzer has timed out.
                    if (buzzer_q) begin
                        if (buzz_q == BUZZ_LAST) begin
                            alarm_buzz = 1'b0;
                        end else begin
                            buzz_d = buzz_q + BUZ_W'(1);
                        end
                    end
                end
            end

            ST_ACKED: begin
                if (!warn_break_oil) begin
                    state_d = ST_CLEARING;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_CLEARING: begin
                if (warn_break_oil) begin
                    // An ack arriving on the same edge as the returning warning
                    // counts as acknowledgement, so the lamp stays steady.
                    if (acked_q || ack) begin
                        state_d = ST_ACKED;
                        acked_d = 1'b1;
                    end else begin
                        enter_alarm = 1'b1;
                    end
                end else begin
                    if (ack) begin
                        acked_d = 1'b1;
                    end
                    if (cnt_q == CLEAR_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_alarm) begin
            state_d    = ST_ALARM;
            blink_d    = '0;
            buzz_d     = '0;
            alarm_lamp = 1'b1;
            alarm_buzz = 1'b1;
        end
    end

    // Registered outputs follow the state being entered on this edge.
    always_comb begin
        lamp_d   = 1'b0;
        buzzer_d = 1'b0;
        active_d = 1'b0;
        unique case (state_d)
            ST_ALARM: begin
                lamp_d   = alarm_lamp;
                buzzer_d = alarm_buzz;
                active_d = 1'b1;
            end
            ST_ACKED, ST_CLEARING: begin
                lamp_d   = 1'b1;
                active_d = 1'b1;
            end
            default: begin
                lamp_d   = 1'b0;
                buzzer_d = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end

    assign lamp         = lamp_q;
    assign buzzer       = buzzer_q;
    assign alarm_active = active_q;
    assign warn_count   = count_q;

endmodule
